cycle_ctl: RTL and testbench

CYCLE_CTL -- requirements
Module: cycle_ctl

---
 rtl/cycle_pkg.sv | 26 ++
 rtl/pulse_timer.sv | 31 +++
 rtl/cycle_ctl.sv | 195 +++++++++++++++++++
 tb/tb_cycle_ctl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_pkg.sv
// Shared definitions for the KC/PC cycle controller: FSM state encoding,
// tick-counter sizing and small helpers used by the top and the pulse timer.
package cycle_pkg;

  localparam int TICK_W   = 4;
  localparam int TICK_MAX = (1 << TICK_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KC   = 2'd1,
    ST_PC   = 2'd2
  } cycle_state_e;

  typedef logic [TICK_W-1:0] tick_t;

  // The timer counts down to zero, so a pulse of N clocks is loaded as N-1.
  function automatic tick_t ticks_to_load(input int ticks);
    return tick_t'(ticks - 1);
  endfunction

  function automatic logic is_trigger(input logic ekc, input logic got,
                                      input logic ekc_fp);
    return ekc_fp | (ekc & got);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Load / count-down tick counter with a terminal flag; one instance is
// time-shared between the KC and PC phases of the cycle controller.
module pulse_timer
  import cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [TICK_W-1:0] load_val,
  input  logic              en,
  output logic              tc
);

  logic [TICK_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TICK_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/cycle_ctl.sv
// Cycle controller: sequences KC then PC pulses per bus cycle, selects fetch or
// interrupt service, and manages run/wait/single-cycle and burst-step control.
module cycle_ctl
  import cycle_pkg::*;
#(
  parameter int KC_TICKS = 3,
  parameter int PC_TICKS = 3,
  parameter int STEP_W   = 8
) (
  input  logic              __clk,
  input  logic              __rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clo,
  input  logic              hlt,
  input  logic              wx,
  input  logic              cycle,
  input  logic              irq,
  input  logic              p,
  input  logic              mc_0,
  input  logic              ekc,
  input  logic              got,
  input  logic              ekc_fp,
  input  logic              step_load,
  input  logic [STEP_W-1:0] step_n,
  output logic              run,
  output logic              wait_o,
  output logic              kc,
  output logic              pc,
  output logic              pr,
  output logic              przerw,
  output logic              sp0,
  output logic              sp1,
  output logic              si1,
  output logic              ovr,
  output logic [STEP_W-1:0] steps_left
);

  localparam logic [TICK_W-1:0] KC_LOAD = ticks_to_load(KC_TICKS);
  localparam logic [TICK_W-1:0] PC_LOAD = ticks_to_load(PC_TICKS);

  cycle_state_e      state;
  cycle_state_e      state_next;
  logic              tmr_load;
  logic [TICK_W-1:0] tmr_val;
  logic              tmr_en;
  logic              tmr_tc;

  logic              trigger;
  logic              busy;
  logic              kc_last;
  logic              dpr;
  logic              dprzerw;
  logic              start_q;
  logic              wait_q;
  logic              cycle_q;
  logic              step_dec;
  logic              step_stop;

  assign trigger = is_trigger(ekc, got, ekc_fp);
  assign busy    = (state != ST_IDLE);

  // A cycle is aborted by clo, so the last KC clock only counts without it.
  assign kc_last = (state == ST_KC) && tmr_tc && !clo;

  assign dpr     = run | cycle_q;
  assign dprzerw = (cycle_q | start_q) & irq & ~p & mc_0;

  assign step_dec  = kc_last && dpr && (steps_left != '0) && !step_load;
  assign step_stop = step_dec && (steps_left == STEP_W'(1));

  pulse_timer u_timer (
    .clk      (__clk),
    .rst_n    (__rst_n),
    .clr      (clo),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_ff @(posedge __clk or negedge __rst_n) begin
    if (!__rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    kc         = 1'b0;
    pc         = 1'b0;
    if (clo) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state_next = ST_KC;
            tmr_load   = 1'b1;
            tmr_val    = KC_LOAD;
          end
        end
        ST_KC: begin
          if (tmr_tc) begin
            state_next = ST_PC;
            tmr_load   = 1'b1;
            tmr_val    = PC_LOAD;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_PC: begin
          if (tmr_tc) begin
            state_next = ST_IDLE;
          end else begin
            tmr_en = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
    kc = (state == ST_KC);
    pc = (state == ST_PC);
  end

  // Clearing sources always win over the matching set source.
  always_ff @(posedge __clk or negedge __rst_n) begin
    if (!__rst_n) begin
      start_q <= 1'b0;
      wait_q  <= 1'b0;
      cycle_q <= 1'b0;
    end else begin
      if (clo || stop || step_stop) begin
        start_q <= 1'b0;
      end else if (start) begin
        start_q <= 1'b1;
      end
      if (clo || stop || si1) begin
        wait_q <= 1'b0;
      end else if (wx && hlt) begin
        wait_q <= 1'b1;
      end
      if (clo || kc_last) begin
        cycle_q <= 1'b0;
      end else if (cycle) begin
        cycle_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge __clk or negedge __rst_n) begin
    if (!__rst_n) begin
      pr     <= 1'b0;
      przerw <= 1'b0;
      ovr    <= 1'b0;
    end else if (clo) begin
      pr     <= 1'b0;
      przerw <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (kc_last) begin
        pr     <= dpr;
        przerw <= dprzerw;
      end
      if (busy && trigger) begin
        ovr <= 1'b1;
      end
    end
  end

  // steps_left of zero means unlimited running; clo leaves it untouched.
  always_ff @(posedge __clk or negedge __rst_n) begin
    if (!__rst_n) begin
      steps_left <= '0;
    end else if (step_load) begin
      steps_left <= step_n;
    end else if (step_dec) begin
      steps_left <= steps_left - STEP_W'(1);
    end
  end

  assign run    = start_q & ~wait_q;
  assign wait_o = wait_q;
  assign sp0    = pc & ~pr & ~przerw;
  assign sp1    = pc & pr & ~przerw;
  assign si1    = pc & przerw;

endmodule

// File: tb/tb_cycle_ctl.sv
// Self-checking bench for cycle_ctl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a cycle-position model.
module tb_cycle_ctl;

  localparam int KC = 3;
  localparam int PC = 2;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, clo, hlt, wx, cycle, irq, p, mc_0;
  logic          ekc, got, ekc_fp, step_load;
  logic [SW-1:0] step_n;
  logic          run, wait_o, kc, pc, pr, przerw, sp0, sp1, si1, ovr;
  logic [SW-1:0] steps_left;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model: position inside a cycle, 0 = idle, 1..KC = KC clocks, then PC clocks.
  int m_pos;
  int m_steps;
  bit m_start, m_wait, m_cycle, m_pr, m_przerw, m_ovr;

  cycle_ctl #(.KC_TICKS(KC), .PC_TICKS(PC), .STEP_W(SW)) dut (
    .__clk      (clk),
    .__rst_n    (rst_n),
    .start      (start),
    .stop       (stop),
    .clo        (clo),
    .hlt        (hlt),
    .wx         (wx),
    .cycle      (cycle),
    .irq        (irq),
    .p          (p),
    .mc_0       (mc_0),
    .ekc        (ekc),
    .got        (got),
    .ekc_fp     (ekc_fp),
    .step_load  (step_load),
    .step_n     (step_n),
    .run        (run),
    .wait_o     (wait_o),
    .kc         (kc),
    .pc         (pc),
    .pr         (pr),
    .przerw     (przerw),
    .sp0        (sp0),
    .sp1        (sp1),
    .si1        (si1),
    .ovr        (ovr),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_kc();
    return (m_pos >= 1) && (m_pos <= KC);
  endfunction

  function automatic bit m_pc();
    return m_pos > KC;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_steps = 0;
    m_start = 0; m_wait = 0; m_cycle = 0; m_pr = 0; m_przerw = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit trig, kc_end, run_now, dpr, dprz, si1_now, sstop;
    if (!rst_n) begin
      model_reset();
    end else begin
      trig    = ekc_fp || (ekc && got);
      kc_end  = (m_pos == KC) && !clo;
      run_now = m_start && !m_wait;
      dpr     = run_now || m_cycle;
      dprz    = (m_cycle || m_start) && irq && !p && mc_0;
      si1_now = m_pc() && m_przerw;
      sstop   = !step_load && kc_end && dpr && (m_steps == 1);
      if (clo) m_ovr = 0;
      else if (m_pos != 0 && trig) m_ovr = 1;
      if (clo) begin m_pr = 0; m_przerw = 0; end
      else if (kc_end) begin m_pr = dpr; m_przerw = dprz; end
      if (step_load) m_steps = int'(step_n);
      else if (kc_end && dpr && m_steps > 0) m_steps = m_steps - 1;
      if (clo || stop || sstop) m_start = 0;
      else if (start) m_start = 1;
      if (clo || stop || si1_now) m_wait = 0;
      else if (wx && hlt) m_wait = 1;
      if (clo || kc_end) m_cycle = 0;
      else if (cycle) m_cycle = 1;
      if (clo) m_pos = 0;
      else if (m_pos == 0) m_pos = trig ? 1 : 0;
      else if (m_pos == KC + PC) m_pos = 0;
      else m_pos = m_pos + 1;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("kc", int'(kc), int'(m_kc()));
      chk("pc", int'(pc), int'(m_pc()));
      chk("run", int'(run), int'(m_start && !m_wait));
      chk("wait_o", int'(wait_o), int'(m_wait));
      chk("pr", int'(pr), int'(m_pr));
      chk("przerw", int'(przerw), int'(m_przerw));
      chk("sp0", int'(sp0), int'(m_pc() && !m_pr && !m_przerw));
      chk("sp1", int'(sp1), int'(m_pc() && m_pr && !m_przerw));
      chk("si1", int'(si1), int'(m_pc() && m_przerw));
      chk("ovr", int'(ovr), int'(m_ovr));
      chk("steps_left", int'(steps_left), m_steps);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stop = 0; clo = 0; hlt = 0; wx = 0; cycle = 0; irq = 0; p = 0;
    mc_0 = 0; ekc = 0; got = 0; ekc_fp = 0; step_load = 0; step_n = '0;
  endtask

  task automatic trigger_tick();
    ekc = 1; got = 1;
    tick();
    ekc = 0; got = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rst_out"}, int'({run, wait_o, kc, pc, pr, przerw, sp0, sp1, si1, ovr}), 0);
    chk({tag, "_rst_steps"}, int'(steps_left), 0);
  endtask

  task automatic apply_random_inputs();
    start     = ($urandom_range(0, 7) == 0);
    stop      = ($urandom_range(0, 19) == 0);
    clo       = ($urandom_range(0, 49) == 0);
    hlt       = ($urandom_range(0, 3) == 0);
    wx        = ($urandom_range(0, 3) == 0);
    cycle     = ($urandom_range(0, 7) == 0);
    irq       = ($urandom_range(0, 1) == 0);
    p         = ($urandom_range(0, 3) == 0);
    mc_0      = ($urandom_range(0, 3) != 0);
    ekc       = ($urandom_range(0, 1) == 0);
    got       = ($urandom_range(0, 1) == 0);
    ekc_fp    = ($urandom_range(0, 9) == 0);
    step_load = ($urandom_range(0, 29) == 0);
    step_n    = SW'($urandom_range(0, 3));
  endtask

  initial begin
    int kc_n, pc_n, sp0_n, sp1_n, si1_n, other_n;
    clear_inputs();
    rst_n = 1;
    #1 rst_n = 0;
    model_reset();
    cmp_en = 1;
    #1 check_reset_outputs("init");
    tick(); tick();
    rst_n = 1;

    // Basic fetch cycle: kc 3 clocks, pc 2 clocks, sp1 during pc.
    start = 1; tick(); start = 0;
    trigger_tick();
    kc_n = 0; pc_n = 0; sp1_n = 0; other_n = 0;
    for (int i = 0; i < 10; i++) begin
      kc_n += int'(kc); pc_n += int'(pc); sp1_n += int'(sp1);
      other_n += int'(sp0 | si1);
      tick();
    end
    chk("fetch_kc_len", kc_n, 3);
    chk("fetch_pc_len", pc_n, 2);
    chk("fetch_sp1_len", sp1_n, 2);
    chk("fetch_sp0_si1", other_n, 0);
    chk("fetch_pr", int'(pr), 1);

    // Interrupt cycle: przerw selected, si1 clears WAIT.
    irq = 1; p = 0; mc_0 = 1; wx = 1; hlt = 1;
    tick();
    wx = 0; hlt = 0;
    chk("irq_wait_set", int'(wait_o), 1);
    chk("irq_run_low", int'(run), 0);
    trigger_tick();
    si1_n = 0;
    for (int i = 0; i < 10; i++) begin
      si1_n += int'(si1);
      tick();
    end
    chk("irq_si1_len", si1_n, 2);
    chk("irq_przerw", int'(przerw), 1);
    chk("irq_wait_clr", int'(wait_o), 0);
    irq = 0; mc_0 = 0;

    // Burst of two steps, then a third cycle falls back to sp0.
    clo = 1; step_load = 1; step_n = 8'd2;
    tick();
    clo = 0; step_load = 0; start = 1;
    tick();
    start = 0;
    chk("step_loaded", int'(steps_left), 2);
    trigger_tick();
    for (int i = 0; i < 8; i++) tick();
    chk("step_after1", int'(steps_left), 1);
    chk("step_run1", int'(run), 1);
    trigger_tick();
    for (int i = 0; i < 8; i++) tick();
    chk("step_after2", int'(steps_left), 0);
    chk("step_run2", int'(run), 0);
    chk("step_pr2", int'(pr), 1);
    trigger_tick();
    sp0_n = 0;
    for (int i = 0; i < 8; i++) begin
      sp0_n += int'(sp0);
      tick();
    end
    chk("step_sp0_len", sp0_n, 2);
    chk("step_pr3", int'(pr), 0);
    chk("step_after3", int'(steps_left), 0);

    // Trigger during PC is ignored and sets ovr; clo clears it.
    start = 1; tick(); start = 0;
    trigger_tick();
    tick(); tick(); tick();
    chk("ovr_in_pc", int'(pc), 1);
    ekc_fp = 1; tick(); ekc_fp = 0;
    tick();
    chk("ovr_set", int'(ovr), 1);
    chk("ovr_no_kc", int'(kc | pc), 0);
    tick();
    chk("ovr_still_idle", int'(kc), 0);
    chk("ovr_unlimited_run", int'(run), 1);
    clo = 1; tick(); clo = 0;
    chk("ovr_clr", int'(ovr), 0);
    chk("ovr_clo_idle", int'(kc | pc), 0);

    // clo on the second KC clock aborts the cycle and drops pr.
    start = 1; tick(); start = 0;
    trigger_tick();
    for (int i = 0; i < 6; i++) tick();
    chk("abort_pr_before", int'(pr), 1);
    trigger_tick();
    tick();
    chk("abort_kc2", int'(kc), 1);
    clo = 1; tick(); clo = 0;
    chk("abort_kc_off", int'(kc), 0);
    chk("abort_pr_clr", int'(pr), 0);
    pc_n = 0;
    for (int i = 0; i < 6; i++) begin
      pc_n += int'(pc);
      tick();
    end
    chk("abort_no_pc", pc_n, 0);

    // Simultaneous set and clear: the clear wins.
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("start_stop", int'(run), 0);
    start = 1; tick(); start = 0;
    chk("start_alone", int'(run), 1);
    wx = 1; hlt = 1; stop = 1; tick(); wx = 0; hlt = 0; stop = 0;
    chk("wait_stop", int'(wait_o), 0);

    // Randomized traffic with occasional mid-cycle asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      apply_random_inputs();
      if ((n % 600) == 599) begin
        rst_n = 0;
        model_reset();
        #1 check_reset_outputs("async");
        tick();
        rst_n = 1;
      end else begin
        tick();
      end
    end

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
